// File: rtl/key_repeater.sv
// Per-button press/release/auto-repeat event generator fed by a debounced level.
// Output pulse names carry a _pulse suffix because release/repeat/event are reserved words.
module key_repeater #(
  parameter int HOLD_DELAY    = 13500000,
  parameter int REPEAT_PERIOD = 2700000,
  parameter int CW            = 24
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       clean,
  input  logic       repeat_en,
  output logic       press,
  output logic       release_pulse,
  output logic       repeat_pulse,
  output logic       event_pulse,
  output logic       held,
  output logic [7:0] repeat_count
);

  typedef enum logic [1:0] {IDLE, PRESSED, REPEATING} state_t;

  localparam logic [CW-1:0] HOLD_TC   = CW'(HOLD_DELAY - 1);
  localparam logic [CW-1:0] REPEAT_TC = CW'(REPEAT_PERIOD - 1);

  state_t        state;
  logic [CW-1:0] cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      press         <= 1'b0;
      release_pulse <= 1'b0;
      repeat_pulse  <= 1'b0;
      event_pulse   <= 1'b0;
      held          <= 1'b0;
      repeat_count  <= 8'd0;
    end else begin
      press         <= 1'b0;
      release_pulse <= 1'b0;
      repeat_pulse  <= 1'b0;
      event_pulse   <= 1'b0;
      case (state)
        IDLE: begin
          if (clean) begin
            press        <= 1'b1;
            event_pulse  <= 1'b1;
            cnt          <= '0;
            repeat_count <= 8'd0;
            state        <= PRESSED;
          end
        end
        PRESSED: begin
          // Release takes priority over a coincident terminal count.
          if (!clean) begin
            release_pulse <= 1'b1;
            cnt           <= '0;
            state         <= IDLE;
          end else if (cnt == HOLD_TC) begin
            cnt   <= '0;
            held  <= 1'b1;
            state <= REPEATING;
            if (repeat_en) begin
              repeat_pulse <= 1'b1;
              event_pulse  <= 1'b1;
              if (repeat_count != 8'hFF) repeat_count <= repeat_count + 8'd1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        REPEATING: begin
          if (!clean) begin
            release_pulse <= 1'b1;
            held          <= 1'b0;
            cnt           <= '0;
            state         <= IDLE;
          end else if (cnt == REPEAT_TC) begin
            // Period keeps running with repeat_en low so re-enabling keeps phase.
            cnt <= '0;
            if (repeat_en) begin
              repeat_pulse <= 1'b1;
              event_pulse  <= 1'b1;
              if (repeat_count != 8'hFF) repeat_count <= repeat_count + 8'd1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          held  <= 1'b0;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_repeater.sv
// Directed bench for key_repeater: short tap, hold/repeat, release on terminal edge,
// repeat_en gating, saturation (period 1 instance) and reset mid-hold.
module tb_key_repeater;

  logic       clock = 1'b0;
  logic       reset, clean, clean1, repeat_en;
  logic       press, release_pulse, repeat_pulse, event_pulse, held;
  logic [7:0] repeat_count;
  logic       press1, release1, repeat1, event1, held1;
  logic [7:0] repeat_count1;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  key_repeater #(.HOLD_DELAY(10), .REPEAT_PERIOD(4), .CW(8)) dut (
    .clock(clock), .reset(reset), .clean(clean), .repeat_en(repeat_en),
    .press(press), .release_pulse(release_pulse), .repeat_pulse(repeat_pulse),
    .event_pulse(event_pulse), .held(held), .repeat_count(repeat_count)
  );

  key_repeater #(.HOLD_DELAY(10), .REPEAT_PERIOD(1), .CW(8)) dut1 (
    .clock(clock), .reset(reset), .clean(clean1), .repeat_en(repeat_en),
    .press(press1), .release_pulse(release1), .repeat_pulse(repeat1),
    .event_pulse(event1), .held(held1), .repeat_count(repeat_count1)
  );

  task automatic cyc();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic chk(input string tag, input int c, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cycle=%0d observed=%0d expected=%0d", tag, c, obs, exp);
    end
  endtask

  task automatic chk_a(input string t, input int c, input logic p, input logic rl,
                       input logic rp, input logic h, input logic [7:0] rc);
    chk({t, ".press"},   c, {7'd0, press},         {7'd0, p});
    chk({t, ".release"}, c, {7'd0, release_pulse}, {7'd0, rl});
    chk({t, ".repeat"},  c, {7'd0, repeat_pulse},  {7'd0, rp});
    chk({t, ".event"},   c, {7'd0, event_pulse},   {7'd0, p | rp});
    chk({t, ".held"},    c, {7'd0, held},          {7'd0, h});
    chk({t, ".count"},   c, repeat_count,          rc);
  endtask

  task automatic chk_b(input string t, input int c, input logic p, input logic rl,
                       input logic rp, input logic h, input logic [7:0] rc);
    chk({t, ".press"},   c, {7'd0, press1},   {7'd0, p});
    chk({t, ".release"}, c, {7'd0, release1}, {7'd0, rl});
    chk({t, ".repeat"},  c, {7'd0, repeat1},  {7'd0, rp});
    chk({t, ".event"},   c, {7'd0, event1},   {7'd0, p | rp});
    chk({t, ".held"},    c, {7'd0, held1},    {7'd0, h});
    chk({t, ".count"},   c, repeat_count1,    rc);
  endtask

  initial begin
    int rc;
    reset = 1'b1; clean = 1'b0; clean1 = 1'b0; repeat_en = 1'b1;
    cyc(); cyc();
    chk_a("reset", 0, 0, 0, 0, 0, 8'd0);
    chk_b("reset1", 0, 0, 0, 0, 0, 8'd0);
    reset = 1'b0;
    cyc();

    // short tap: press in cycle 0, release in cycle 3
    for (int c = 0; c <= 4; c++) begin
      clean = (c < 3);
      cyc();
      chk_a("tap", c, c == 0, c == 3, 0, 0, 8'd0);
    end

    // hold 30 cycles: repeats at 10,14,18,22,26
    for (int c = 0; c <= 31; c++) begin
      clean = (c < 30);
      cyc();
      rc = (c < 10) ? 0 : (c < 30 ? ((c - 10) / 4 + 1) : 5);
      if (rc > 5) rc = 5;
      chk_a("hold", c, c == 0, c == 30,
            (c >= 10 && c < 30 && (c - 10) % 4 == 0), (c >= 10 && c < 30), 8'(rc));
    end

    // release on the terminal edge: release wins, no repeat; count cleared by press
    for (int c = 0; c <= 11; c++) begin
      clean = (c < 10);
      cyc();
      chk_a("term", c, c == 0, c == 10, 0, 0, 8'd0);
    end

    // repeat_en low until edge 17: held at 10, silent wrap at 14, first repeat at 18
    for (int c = 0; c <= 22; c++) begin
      clean     = (c < 21);
      repeat_en = (c >= 17);
      cyc();
      chk_a("gate", c, c == 0, c == 21, c == 18, (c >= 10 && c < 21), (c >= 18) ? 8'd1 : 8'd0);
    end
    repeat_en = 1'b1;

    // saturation on the period-1 instance
    for (int c = 0; c <= 301; c++) begin
      clean1 = (c < 300);
      cyc();
      rc = (c < 10) ? 0 : c - 9;
      if (rc > 255) rc = 255;
      chk_b("sat", c, c == 0, c == 300, (c >= 10 && c < 300), (c >= 10 && c < 300), 8'(rc));
    end
    for (int c = 0; c <= 2; c++) begin
      clean1 = (c < 1);
      cyc();
      chk_b("sat_clr", c, c == 0, c == 1, 0, 0, 8'd0);
    end

    // reset mid-hold at edge 12: outputs cleared, no release, fresh press in cycle 13
    for (int c = 0; c <= 14; c++) begin
      clean = 1'b1;
      reset = (c == 12);
      cyc();
      if (c <= 11)
        chk_a("rst_hold", c, c == 0, 0, c == 10, c >= 10, (c >= 10) ? 8'd1 : 8'd0);
      else
        chk_a("rst_hold", c, c == 13, 0, 0, 0, 8'd0);
    end
    reset = 1'b0;
    clean = 1'b0;
    cyc();
    chk_a("rst_rel", 15, 0, 1, 0, 0, 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/key_repeater.md
Name: key_repeater

Overview:
- Consumes the clean level produced by the debounce stage for one button.
- Turns it into single-cycle control events for the pixel controller: press, release and timed auto-repeat while held.
- Sits between the debounce output and the mode/brightness control logic, so holding a button steps a value at a fixed rate.
- One instance per button.

Parameters:
HOLD_DELAY, 13500000, cycles from press pulse to first repeat pulse (0.5 s at 27 MHz); legal range 2..2^CW
REPEAT_PERIOD, 2700000, cycles between successive repeat pulses (0.1 s at 27 MHz); legal range 1..2^CW
CW, 24, width of internal cycle counter

Ports:
clock  input  1  system clock, single clock domain
reset  input  1  synchronous, active-high reset
clean  input  1  debounced button level, 1 = pressed
repeat_en  input  1  1 = emit repeat pulses while held; 0 = hold detection only
press  output  1  one-cycle pulse on press
release  output  1  one-cycle pulse on release
repeat  output  1  one-cycle pulse per auto-repeat interval
event  output  1  press OR repeat (one-cycle), for step-on-press-and-hold consumers
held  output  1  level, high while in REPEATING state
repeat_count  output  8  repeats since last press, saturating at 255

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Ports are named clock and reset.
- All outputs are registered.
- Reset:
  - state=IDLE, counter=0.
  - press, release, repeat, event, held = 0; repeat_count = 0.
  - Reset mid-press returns to IDLE with no release pulse.
  - If clean is still 1 after reset deasserts, it is treated as a new press on the first non-reset edge.
- States: IDLE, PRESSED, REPEATING.
- Pulse outputs (press, release, repeat, event) default to 0 every cycle. They are high for exactly one cycle when set.
- IDLE:
  - Edge sampling clean=1: press<=1, event<=1, counter<=0, repeat_count<=0, go PRESSED.
  - Latency is 1 cycle: press is visible the cycle after the first edge that sees clean=1.
- PRESSED:
  - Edge with clean=0: release<=1, go IDLE, counter<=0.
  - Else, if counter==HOLD_DELAY-1: go REPEATING, counter<=0, held<=1.
    - If repeat_en=1: repeat<=1, event<=1, repeat_count increments.
  - Else: counter increments.
  - Net effect: first repeat is HOLD_DELAY cycles after press.
- REPEATING:
  - Edge with clean=0: release<=1, held<=0, go IDLE, counter<=0.
  - Else, if counter==REPEAT_PERIOD-1: counter<=0.
    - If repeat_en=1: repeat<=1, event<=1, repeat_count increments.
  - Else: counter increments.
  - The counter keeps running while repeat_en=0. Re-enabling does not restart the phase.
  - REPEAT_PERIOD=1 gives repeat high every cycle.
- Simultaneous events:
  - clean=0 on the same edge as a terminal count: release wins; no repeat, no count increment.
- repeat_count:
  - Saturates at 255. Increments stop; repeat pulses continue.
  - Holds its value after release until the next press clears it.
- held is never high in IDLE or PRESSED.
- event is never high in the same cycle as release.
- Counter arithmetic is unsigned CW bits. Terminal compares use parameter minus 1 truncated to CW.

Test Plan:
(Bench uses HOLD_DELAY=10, REPEAT_PERIOD=4, CW=8; cycle N = cycle after edge N; edge 0 = first edge sampling clean=1.)
- Short tap: clean=1 at edge 0, clean=0 at edge 3 -> press=1 in cycle 0 only; release=1 in cycle 3 only; repeat, held never high; repeat_count=0.
- Hold: clean=1 from edge 0 for 30 cycles, repeat_en=1 -> repeat and event in cycles 10, 14, 18, 22, 26; held=1 from cycle 10; repeat_count=5 at cycle 26; release in cycle 30, held=0.
- Release on terminal edge: clean=1 edges 0..9, clean=0 at edge 10 -> release in cycle 10, no repeat, repeat_count=0, held=0.
- repeat_en=0 during hold, raised at edge 17 -> held=1 at cycle 10 with no repeat in 10 or 14; first repeat at cycle 18, phase unchanged.
- Saturation: REPEAT_PERIOD=1, hold 300 cycles -> repeat every cycle from cycle 10; repeat_count stops at 255; next press clears it to 0.
- Reset mid-hold: assert reset at edge 12 with clean=1, deassert at edge 13 -> all outputs 0 in cycle 12, no release; press in cycle 13.
